// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and parameter defaults for the instruction-memory loader
package imem_loader_pkg;
  localparam int D_DEF = 12;
  localparam int W_DEF = 9;
  localparam int CW_DEF = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_LO,
    S_LOAD_HI,
    S_WRITE,
    S_RUN,
    S_DONE
  } state_e;
endpackage

// File: rtl/imem_loader_sat_counter.sv
// sat_counter: CW-bit up counter with synchronous clear that holds at all-ones
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] q_o
);
  logic [CW-1:0] q_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) q_q <= '0;
    else if (en_i && q_q != '1) q_q <= q_q + CW'(1);
  end
  assign q_o = q_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams byte pairs into instruction RAM, then releases the core and times its run
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int D = D_DEF,
  parameter int W = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  word_count,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [D-1:0]  wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          err,
  output logic [CW-1:0] run_cycles
);
  state_e state_q, state_d;
  logic [D-1:0] wc_q, wr_addr_q;
  logic [7:0] lo_q;
  logic hi_q, first_q, err_q;
  logic byte_ready_q, wr_en_q, core_reset_q, busy_q, finished_q;
  logic byte_ready_d, wr_en_d, core_reset_d, busy_d, finished_d;
  logic accept, wc_zero, xfer, bad_hi, last;
  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
  assign wc_zero = word_count == '0;
  assign xfer = byte_valid && byte_ready_q;
  assign bad_hi = byte_data[7:1] != 7'd0;
  assign last = wr_addr_q == wc_q - D'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      byte_ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q <= wr_en_d;
      core_reset_q <= core_reset_d;
      busy_q <= busy_d;
      finished_q <= finished_d;
    end
  end
  // first_q masks core_done while the core is still coming out of reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = wc_zero ? S_IDLE : S_LOAD_LO;
      S_LOAD_LO: if (xfer) state_d = S_LOAD_HI;
      S_LOAD_HI: if (xfer) state_d = bad_hi ? S_IDLE : S_WRITE;
      S_WRITE: state_d = last ? S_RUN : S_LOAD_LO;
      S_RUN: if (!first_q && core_done) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    byte_ready_d = state_d == S_LOAD_LO || state_d == S_LOAD_HI;
    wr_en_d = state_d == S_WRITE;
    core_reset_d = state_d != S_RUN;
    busy_d = byte_ready_d || wr_en_d || state_d == S_RUN;
    finished_d = state_d == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wc_q <= '0;
      wr_addr_q <= '0;
      lo_q <= '0;
      hi_q <= 1'b0;
      first_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      first_q <= state_q != S_RUN;
      if (accept) begin
        wc_q <= word_count;
        err_q <= wc_zero;
        if (!wc_zero) wr_addr_q <= '0;
      end
      if (state_q == S_LOAD_LO && xfer) lo_q <= byte_data;
      if (state_q == S_LOAD_HI && xfer) begin
        if (bad_hi) err_q <= 1'b1;
        else hi_q <= byte_data[0];
      end
      if (state_q == S_WRITE && !last) wr_addr_q <= wr_addr_q + D'(1);
    end
  end
  sat_counter #(.CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (reset),
    .clr_i(accept && !wc_zero),
    .en_i (state_q == S_RUN && state_d != S_DONE),
    .q_o  (run_cycles)
  );
  assign byte_ready = byte_ready_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = W'({hi_q, lo_q});
  assign core_reset = core_reset_q;
  assign busy = busy_q;
  assign finished = finished_q;
  assign err = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of load, stall, format error, run timing, reset and saturation
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset, start, byte_valid, core_done;
  logic [11:0] word_count;
  logic [7:0] byte_data;
  logic byte_ready, wr_en, core_reset, busy, finished, err;
  logic [11:0] wr_addr;
  logic [8:0] wr_data;
  logic [15:0] run_cycles;
  logic reset2, start2, byte_valid2, core_done2;
  logic [11:0] word_count2;
  logic [7:0] byte_data2;
  logic byte_ready2, wr_en2, core_reset2, busy2, finished2, err2;
  logic [11:0] wr_addr2;
  logic [8:0] wr_data2;
  logic [3:0] run_cycles2;
  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] log_addr[$];
  logic [8:0] log_data[$];
  logic [8:0] exp_d[3] = '{9'h13F, 9'h000, 9'h1FF};

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .core_reset(core_reset),
    .core_done(core_done), .busy(busy), .finished(finished), .err(err),
    .run_cycles(run_cycles)
  );

  imem_loader #(.CW(4)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .word_count(word_count2),
    .byte_valid(byte_valid2), .byte_data(byte_data2), .byte_ready(byte_ready2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .core_reset(core_reset2),
    .core_done(core_done2), .busy(busy2), .finished(finished2), .err(err2),
    .run_cycles(run_cycles2)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_byte_ready"}, byte_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_finished"}, finished, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_run_cycles"}, run_cycles, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    chk("byte_ready_wait", byte_ready, 1);
    byte_valid = 1'b1;
    byte_data = b;
    tick();
    byte_valid = 1'b0;
    byte_data = 8'h00;
  endtask

  task automatic do_start(input logic [11:0] wc);
    word_count = wc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_three_writes(input string tag);
    chk({tag, "_nwrites"}, log_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_data.size()) begin
        chk({tag, "_addr"}, log_addr[i], i);
        chk({tag, "_data"}, log_data[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    core_done = 1'b0; word_count = 12'd0;
    reset2 = 1'b1; start2 = 1'b0; byte_valid2 = 1'b0; byte_data2 = 8'h00;
    core_done2 = 1'b0; word_count2 = 12'd0;
    tick();
    tick();
    chk_reset("rst0");
    reset = 1'b0;
    reset2 = 1'b0;
    tick();
    chk_reset("idle");

    // three-word load, back-to-back bytes
    do_start(12'd3);
    chk("t1_ready", byte_ready, 1);
    chk("t1_busy", busy, 1);
    chk("t1_core_reset", core_reset, 1);
    send_byte(8'h3F);
    send_byte(8'h01);
    chk("t1_wr_en0", wr_en, 1);
    chk("t1_wr_addr0", wr_addr, 0);
    chk("t1_wr_data0", wr_data, 9'h13F);
    send_byte(8'h00);
    chk("t1_wr_en_lo", wr_en, 0);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h01);
    chk("t1_wr_addr2", wr_addr, 2);
    tick();
    chk("t1_run_core_reset", core_reset, 0);
    chk("t1_run_busy", busy, 1);
    chk("t1_run_wr_en", wr_en, 0);
    check_three_writes("t1");
    core_done = 1'b1;
    tick();
    chk("t1_first_run_ignored", finished, 0);
    tick();
    core_done = 1'b0;
    chk("t1_finished", finished, 1);
    chk("t1_run_cycles", run_cycles, 1);
    chk("t1_done_core_reset", core_reset, 1);
    chk("t1_done_busy", busy, 0);

    // same load with a five-cycle stall between low and high byte
    log_addr.delete();
    log_data.delete();
    do_start(12'd3);
    chk("t2_run_cycles_clr", run_cycles, 0);
    chk("t2_finished_clr", finished, 0);
    send_byte(8'h3F);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_stall_no_wr", log_data.size(), 0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h01);
    tick();
    check_three_writes("t2");
    tick();
    chk("t2_in_run", core_reset, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset("t2_midrun_rst");

    // malformed high byte
    log_addr.delete();
    log_data.delete();
    do_start(12'd1);
    send_byte(8'h55);
    send_byte(8'h02);
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_ready", byte_ready, 0);
    chk("t3_core_reset", core_reset, 1);
    tick();
    chk("t3_no_write", log_data.size(), 0);

    // one word, core halts on its 11th run cycle
    do_start(12'd1);
    chk("t4_err_clr", err, 0);
    send_byte(8'h34);
    send_byte(8'h01);
    chk("t4_wr_data", wr_data, 9'h134);
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("t4_still_run", busy, 1);
    chk("t4_not_finished", finished, 0);
    for (int i = 0; i < 9; i++) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("t4_run_cycles", run_cycles, 10);
    chk("t4_finished", finished, 1);
    chk("t4_core_reset", core_reset, 1);
    tick();
    chk("t4_held", run_cycles, 10);

    // reset in the middle of LOAD_HI, then a zero-length request
    do_start(12'd2);
    send_byte(8'hAA);
    chk("t5_in_load_hi", byte_ready, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset("t5_midload_rst");
    do_start(12'd0);
    chk("t5_zero_err", err, 1);
    chk("t5_zero_busy", busy, 0);
    chk("t5_zero_ready", byte_ready, 0);
    chk("t5_zero_core_reset", core_reset, 1);

    // 4-bit run counter saturates
    word_count2 = 12'd1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    byte_valid2 = 1'b1;
    byte_data2 = 8'h00;
    tick();
    tick();
    byte_valid2 = 1'b0;
    chk("t6_wr_en", wr_en2, 1);
    tick();
    chk("t6_run", core_reset2, 0);
    for (int i = 0; i < 14; i++) tick();
    chk("t6_count14", run_cycles2, 14);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_saturated", run_cycles2, 15);
    chk("t6_still_busy", busy2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter D, default 12, meaning instruction-address width (matches core program counter).
REQ-002 SHALL have parameter W, default 9, meaning machine-code word width.
REQ-003 SHALL have parameter CW, default 16, meaning run-cycle counter width.
REQ-004 SHALL have one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-008 word_count  input  D  number of instruction words to load; sampled when start is accepted.
REQ-009 byte_valid  input  1  upstream byte stream valid.
REQ-010 byte_data  input  8  byte stream; per word: low byte (bits 7:0), then high byte (bit 0 = word bit 8).
REQ-011 byte_ready  output  1  block accepts byte this cycle.
REQ-012 wr_en  output  1  instruction-RAM write strobe.
REQ-013 wr_addr  output  D  instruction-RAM write address.
REQ-014 wr_data  output  W  instruction-RAM write data.
REQ-015 core_reset  output  1  reset driven to the processor core.
REQ-016 core_done  input  1  processor halt indication (core "done").
REQ-017 busy  output  1  high in LOAD_LO, LOAD_HI, WRITE, RUN.
REQ-018 finished  output  1  high in DONE.
REQ-019 err  output  1  sticky format/argument error; cleared by reset or accepted start.
REQ-020 run_cycles  output  CW  clock cycles the core ran before core_done.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD_LO, LOAD_HI, WRITE, RUN, DONE; all outputs registered.
REQ-022 IDLE/DONE + start, word_count!=0 -> LOAD_LO; wr_addr<=0, run_cycles<=0, err<=0.
REQ-023 IDLE/DONE + start, word_count==0 -> set err, remain/return IDLE; core_reset stays 1.
REQ-024 byte_ready SHALL be 1 exactly in LOAD_LO and LOAD_HI; transfer occurs only when byte_valid && byte_ready.
REQ-025 LOAD_LO transfer: capture byte as wr_data[7:0] -> LOAD_HI.
REQ-026 LOAD_HI transfer with byte_data[7:1]==0: wr_data[8]<=byte_data[0] -> WRITE.
REQ-027 LOAD_HI transfer with byte_data[7:1]!=0: set err, discard word, -> IDLE, no write.
REQ-028 WRITE: wr_en=1 for exactly one cycle at current wr_addr; latency from high-byte acceptance to wr_en = 1 cycle.
REQ-029 WRITE exit: if wr_addr==word_count-1 -> RUN, else wr_addr+1, -> LOAD_LO; wr_addr never wraps past word_count-1.
REQ-030 core_reset SHALL be 1 in every state except RUN; deasserts first cycle of RUN.
REQ-031 RUN: core_done ignored in the first RUN cycle (core leaving reset); thereafter core_done==1 -> DONE.
REQ-032 run_cycles increments once per RUN cycle in which the transition to DONE is not taken; saturates at 2^CW-1.
REQ-033 DONE: core_reset=1, finished=1, run_cycles held until next accepted start.
REQ-034 start outside IDLE/DONE SHALL be ignored; byte_valid outside LOAD states SHALL be ignored (no implicit buffering).

Reset
REQ-035 reset SHALL force IDLE from any state, including mid-load and mid-run, on the next clock edge.
REQ-036 Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_reset=1, busy=0, finished=0, err=0, run_cycles=0.

Structure
REQ-037 Package imem_loader_pkg SHALL hold the state enum and the D/W/CW defaults shared with the top level.
REQ-038 One sub-module, sat_counter (CW-bit saturating counter with clear and enable), SHALL implement run_cycles.

Verification
REQ-039 word_count=3, bytes 0x3F,0x01,0x00,0x00,0xFF,0x01 -> writes (0,0x13F),(1,0x000),(2,0x1FF); each wr_en one cycle; then RUN.
REQ-040 Stall byte_valid 5 cycles between low and high byte -> identical writes, no spurious wr_en.
REQ-041 High byte 0x02 -> err=1, state IDLE, no write, core_reset=1.
REQ-042 Load 1 word, core_done asserted on 11th RUN cycle -> run_cycles=10, finished=1, core_reset=1; core_done forced high in first RUN cycle is ignored.
REQ-043 reset asserted mid-LOAD_HI and mid-RUN -> all outputs at reset values next cycle; start with word_count=0 -> err=1.
REQ-044 CW=4, core_done never asserted for 20 cycles -> run_cycles saturates at 15.
